// File: rtl/latch_if.sv
// Latch datapath bundle: controls and data toward the latch, q (and optional q_changed) back.
// q_changed exists only when LATCH_CHANGE_FLAG_EN is defined.
interface latch_if #(
    parameter int LAT_WIDTH = 4
);
    logic                 Aclr;
    logic                 Aset;
    logic                 gate;
    logic [LAT_WIDTH-1:0] data;
    logic [LAT_WIDTH-1:0] q;
`ifdef LATCH_CHANGE_FLAG_EN
    logic                 q_changed;
`endif

`ifdef LATCH_CHANGE_FLAG_EN
    modport master (output Aclr, Aset, gate, data, input q, q_changed);
    modport slave  (input Aclr, Aset, gate, data, output q, q_changed);
`else
    modport master (output Aclr, Aset, gate, data, input q);
    modport slave  (input Aclr, Aset, gate, data, output q);
`endif
endinterface

// File: rtl/latch.sv
// latch: LAT_WIDTH-bit transparent latch, held state kept in a clk register (no latch primitive).
// Latency: Aclr/Aset/gate/data reach q combinationally; hold_q follows one clk edge later.
// Backpressure: none, always accepts. Macro LATCH_CHANGE_FLAG_EN adds registered q_changed.
module latch #(
    parameter int                   LAT_WIDTH  = 4,
    parameter logic [LAT_WIDTH-1:0] ASET_VALUE = {LAT_WIDTH{1'b1}}
) (
    input  logic   clk,
    input  logic   rst_n,
    latch_if.slave lif
);

    logic [LAT_WIDTH-1:0] hold_q;
    logic [LAT_WIDTH-1:0] hold_nxt;

    // Same priority feeds both the register and the output, so q is simply the next state.
    always_comb begin
        hold_nxt = hold_q;
        if (lif.Aclr) begin
            hold_nxt = '0;
        end else if (lif.Aset) begin
            hold_nxt = ASET_VALUE;
        end else if (lif.gate) begin
            hold_nxt = lif.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_nxt;
        end
    end

    assign lif.q = rst_n ? hold_nxt : '0;

`ifdef LATCH_CHANGE_FLAG_EN
    logic q_changed_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_changed_r <= 1'b0;
        end else begin
            q_changed_r <= (hold_nxt != hold_q);
        end
    end

    assign lif.q_changed = q_changed_r;
`endif

endmodule

// File: tb/tb_latch.sv
// Bench for latch: directed vector table, hand sequences for reset/force corners, random mix.
module tb_latch;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    latch_if #(.LAT_WIDTH(W)) lif ();

    latch #(.LAT_WIDTH(W), .ASET_VALUE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lif   (lif)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0] sb_q[$];
    logic [W-1:0] m_hold;
    logic         m_chg;

    typedef struct packed {
        logic         aclr;
        logic         aset;
        logic         gate;
        logic [W-1:0] data;
        logic [W-1:0] exp_q;
        logic [2:0]   extra;
    } vec_t;

    vec_t vecs[14];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] ref_next();
        if (lif.Aclr)      return '0;
        else if (lif.Aset) return 4'hF;
        else if (lif.gate) return lif.data;
        else               return m_hold;
    endfunction

    function automatic logic [W-1:0] ref_q();
        return rst_n ? ref_next() : '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold <= '0;
            m_chg  <= 1'b0;
        end else begin
            m_chg  <= (ref_next() != m_hold);
            m_hold <= ref_next();
        end
    end

    task automatic drive(input logic c, input logic s, input logic g, input logic [W-1:0] d);
        lif.Aclr = c;
        lif.Aset = s;
        lif.gate = g;
        lif.data = d;
    endtask

    task automatic expect_q(input logic [W-1:0] e);
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string name);
        logic [W-1:0] e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, q=%h", name, lif.q);
        end else begin
            e = sb_q.pop_front();
            if (lif.q !== e) begin
                errors++;
                $display("FAIL %s: q=%h expected %h at %0t", name, lif.q, e, $time);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            aclr  aset  gate  data   exp_q  extra
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'h5, 4'h5, 3'd2};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'h3, 4'h5, 3'd5};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 3'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 3'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h3, 4'hF, 3'd2};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'h3, 4'h0, 3'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 3'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'h9, 4'h9, 3'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'h9, 4'hF, 3'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'h2, 4'hF, 3'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 3'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'h7, 4'h0, 3'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'h4, 4'hF, 3'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4'h4, 4'h0, 3'd0};

        // Reset with gate open, then release: q follows data at once.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 4'hA);
        #3;
        expect_q(4'h0); sb_check("reset_q");
        @(posedge clk); #2;
        expect_q(4'h0); sb_check("reset_hold");
        #5 rst_n = 1'b1;
        #1;
        expect_q(4'hA); sb_check("release_transparent");
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 1'b0, 4'h3);
        #1;
        expect_q(4'hA); sb_check("release_hold");

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #2;
            drive(vecs[i].aclr, vecs[i].aset, vecs[i].gate, vecs[i].data);
            #1;
            expect_q(vecs[i].exp_q); sb_check($sformatf("vec%0d", i));
            for (int k = 0; k < int'(vecs[i].extra); k++) begin
                @(posedge clk); #3;
                expect_q(vecs[i].exp_q); sb_check($sformatf("vec%0d_hold%0d", i, k));
            end
        end

        // Reset mid-operation overrides everything; release with Aset active.
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 1'b1, 4'hA);
        #1;
        expect_q(4'hA); sb_check("pre_mid_reset");
        #1 rst_n = 1'b0;
        #1;
        expect_q(4'h0); sb_check("reset_mid");
        drive(1'b1, 1'b1, 1'b1, 4'hA);
        #1;
        expect_q(4'h0); sb_check("reset_overrides_force");
        @(posedge clk); #2;
        drive(1'b0, 1'b1, 1'b0, 4'h2);
        rst_n = 1'b1;
        #1;
        expect_q(4'hF); sb_check("release_aset");
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 1'b0, 4'h2);
        #1;
        expect_q(4'hF); sb_check("aset_persist");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        expect_q(4'h0); sb_check("release_idle");

`ifdef LATCH_CHANGE_FLAG_EN
        // hold_q: 0 -> 5, 5 -> 5, 5 -> 5, 5 -> 6, 6 -> 6
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 1'b1, 4'h5);
        @(posedge clk); #3;
        @(posedge clk); #1;
        check_bit("chg_same_a", lif.q_changed, 1'b0);
        @(posedge clk); #1;
        check_bit("chg_same_b", lif.q_changed, 1'b0);
        #1 drive(1'b0, 1'b0, 1'b1, 4'h6);
        @(posedge clk); #1;
        check_bit("chg_pulse", lif.q_changed, 1'b1);
        @(posedge clk); #1;
        check_bit("chg_pulse_end", lif.q_changed, 1'b0);
`endif

        // Random mix, inputs change twice per cycle, q compared every half-cycle.
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            expect_q(ref_q()); sb_check("rand_edge");
`ifdef LATCH_CHANGE_FLAG_EN
            check_bit("rand_chg", lif.q_changed, m_chg);
`endif
            #1;
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
            #1;
            expect_q(ref_q()); sb_check("rand_a");
            @(negedge clk); #2;
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
            #1;
            expect_q(ref_q()); sb_check("rand_b");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
